fsm_ab_steer_driver: RTL and testbench
======================================

Name: fsm_ab_steer_driver

Overview:
- Initiator for the 2-input/3-state `a`/`b` FSM (remote outputs a 3-bit state code on `dout`).
- Accepts a target-state request and emits the single-cycle `a`/`b` pattern that moves the remote FSM there.
- Confirms the move by watching the remote code, retries on mismatch, and returns an ok/err response.
- Sits beside the remote FSM as its controller/test driver on the same clock.

Parameters:
- MAX_RETRY, 3, drive attempts per request before reporting error (min 1).
- STAT_W, 16, width of statistic counters (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_target  in  2  requested remote state 0..2; 3 is illegal
- req_vld  in  1  request valid
- req_rd  out  1  request ready
- st_code  in  3  remote FSM state code (001=st0, 010=st1, 011=st2, others illegal)
- a  out  1  drive to remote `a`, registered
- b  out  1  drive to remote `b`, registered
- resp_ok  out  1  response: target reached
- resp_err  out  1  response: illegal target, illegal code or retries exhausted
- resp_vld  out  1  response valid
- resp_rd  in  1  response ready

Behaviour:
- Reset: FSM=IDLE, a=b=0, req_rd=0, resp_vld=resp_ok=resp_err=0, retry counter=0. Async assert, sync release.
- Drive pattern per target; each pattern is valid from any remote state:
  - target0 = (a,b)=(1,0)
  - target1 = (0,1)
  - target2 = (1,1)
  - (0,0) holds the remote state and is always driven outside DRIVE.
- States: IDLE, DRIVE, CHECK, RESP.
- IDLE:
  - req_rd=1; a request is accepted on req_vld&req_rd.
  - Target 3 -> RESP with err, no drive.
  - st_code illegal -> RESP with err.
  - st_code already equals the target code -> RESP with ok, no drive.
  - Otherwise latch the target, clear retries, go to DRIVE.
- DRIVE:
  - a/b hold the pattern for exactly one cycle; the remote samples it on the edge leaving DRIVE.
  - Increment retries; go to CHECK.
- CHECK:
  - a=b=0. Sample st_code, which shows the remote's new state this cycle.
  - Match -> RESP ok.
  - Illegal code -> RESP err.
  - Mismatch with retries<MAX_RETRY -> DRIVE.
  - Otherwise -> RESP err.
- RESP:
  - resp_vld=1 with exactly one of resp_ok/resp_err set; both are stable until resp_vld&resp_rd, then return to IDLE.
  - req_rd=0 outside IDLE, so only one request is outstanding.
- Latency, request accept to resp_vld:
  - Success on first try: 3 cycles (DRIVE, CHECK, RESP).
  - Each retry adds 2 cycles.
  - Skip and illegal cases: 1 cycle.
- resp_rd may already be high when resp_vld rises; the response is consumed in that same cycle.
- req_vld without acceptance is ignored; req_target is sampled only at acceptance.
- Reset mid-operation: outputs return immediately to their reset values, the in-flight request is dropped, and no response is issued.

Optional Feature:
- FSM_AB_STEER_STATS_EN defined:
  - Adds output ports stat_ok[STAT_W-1:0], stat_err[STAT_W-1:0], stat_retry[STAT_W-1:0], and input stat_clr.
  - Counters increment on ok/err response handshake and on each re-drive.
  - All counters saturate at all-ones and clear on stat_clr or reset.
  - stat_clr wins over a same-cycle increment.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fsm_ab_steer_pkg:
  - controller state enum (IDLE/DRIVE/CHECK/RESP)
  - remote code constants CODE_ST0..CODE_ST2
  - function mapping target to the (a,b) pattern
  - function mapping target to the expected code
- Sub-module fsm_ab_steer_stats (saturating counter triplet), instantiated only under the macro.

Test Plan:
- Remote in st0 (code 001), request target 2 -> a=b=1 for one cycle, resp_vld with resp_ok 3 cycles after accept, remote code 011.
- Remote in st1, request target 1 -> no a/b activity, resp_ok one cycle after accept.
- Request target 3 -> resp_err one cycle after accept, a=b=0 throughout.
- Remote model forced to ignore inputs, MAX_RETRY=3 -> exactly three one-cycle drives spaced 2 cycles apart, then resp_err.
- Hold resp_rd=0 for 5 cycles -> resp_vld/resp_ok stable, req_rd=0; release -> IDLE, next request accepted.
- Assert rst_n low during CHECK -> a,b,resp_vld low immediately; after release the first request completes normally; with the stats macro, counters read 0 after reset and saturate at 0xFFFF.

Source files
------------

// File: rtl/fsm_ab_steer_pkg.sv
// Shared types and encodings for the a/b steering driver and its remote 3-state FSM.
package fsm_ab_steer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } ctrl_state_t;

  localparam logic [2:0] CODE_ST0 = 3'b001;
  localparam logic [2:0] CODE_ST1 = 3'b010;
  localparam logic [2:0] CODE_ST2 = 3'b011;

  // Returns {a,b}; each pattern lands the remote in the target from any state.
  function automatic logic [1:0] target_ab(input logic [1:0] target);
    case (target)
      2'd0:    target_ab = 2'b10;
      2'd1:    target_ab = 2'b01;
      2'd2:    target_ab = 2'b11;
      default: target_ab = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] target_code(input logic [1:0] target);
    case (target)
      2'd0:    target_code = CODE_ST0;
      2'd1:    target_code = CODE_ST1;
      2'd2:    target_code = CODE_ST2;
      default: target_code = 3'b000;
    endcase
  endfunction

  function automatic logic code_legal(input logic [2:0] code);
    code_legal = (code == CODE_ST0) || (code == CODE_ST1) || (code == CODE_ST2);
  endfunction

endpackage

// File: rtl/fsm_ab_steer_stats.sv
// Saturating ok/err/retry event counters for the steering driver.
module fsm_ab_steer_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc_ok,
  input  logic              inc_err,
  input  logic              inc_retry,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_err,
  output logic [STAT_W-1:0] stat_retry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok    <= '0;
      stat_err   <= '0;
      stat_retry <= '0;
    end else if (clr) begin
      stat_ok    <= '0;
      stat_err   <= '0;
      stat_retry <= '0;
    end else begin
      if (inc_ok && (stat_ok != '1))       stat_ok    <= stat_ok + 1'b1;
      if (inc_err && (stat_err != '1))     stat_err   <= stat_err + 1'b1;
      if (inc_retry && (stat_retry != '1)) stat_retry <= stat_retry + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_ab_steer_driver.sv
// Request/response driver that steers the remote a/b FSM to a target state and confirms it.
// Define FSM_AB_STEER_STATS_EN to add the stat_* counters and the stat_clr input.
//
//   state | meaning
//   IDLE  | ready for a request; screens illegal target/code and already-there cases
//   DRIVE | a/b carry the target pattern for one cycle
//   CHECK | a/b idle, compare remote code against the target
//   RESP  | response held until resp_rd
module fsm_ab_steer_driver
  import fsm_ab_steer_pkg::*;
#(
  parameter int MAX_RETRY = 3
`ifdef FSM_AB_STEER_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_target,
  input  logic       req_vld,
  output logic       req_rd,
  input  logic [2:0] st_code,
  output logic       a,
  output logic       b,
  output logic       resp_ok,
  output logic       resp_err,
  output logic       resp_vld,
  input  logic       resp_rd
`ifdef FSM_AB_STEER_STATS_EN
  , input  logic              stat_clr
  , output logic [STAT_W-1:0] stat_ok
  , output logic [STAT_W-1:0] stat_err
  , output logic [STAT_W-1:0] stat_retry
`endif
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  ctrl_state_t     state;
  logic [1:0]      target_q;
  logic [RW-1:0]   retries;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      target_q <= 2'd0;
      retries  <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      req_rd   <= 1'b0;
      resp_vld <= 1'b0;
      resp_ok  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_rd <= 1'b1;
          if (req_vld && req_rd) begin
            req_rd   <= 1'b0;
            target_q <= req_target;
            if ((req_target == 2'd3) || !code_legal(st_code)) begin
              state    <= ST_RESP;
              resp_vld <= 1'b1;
              resp_err <= 1'b1;
            end else if (st_code == target_code(req_target)) begin
              state    <= ST_RESP;
              resp_vld <= 1'b1;
              resp_ok  <= 1'b1;
            end else begin
              state    <= ST_DRIVE;
              retries  <= '0;
              {a, b}   <= target_ab(req_target);
            end
          end
        end
        ST_DRIVE: begin
          a       <= 1'b0;
          b       <= 1'b0;
          retries <= retries + RW'(1);
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (st_code == target_code(target_q)) begin
            state    <= ST_RESP;
            resp_vld <= 1'b1;
            resp_ok  <= 1'b1;
          end else if (!code_legal(st_code) || (retries >= RW'(MAX_RETRY))) begin
            state    <= ST_RESP;
            resp_vld <= 1'b1;
            resp_err <= 1'b1;
          end else begin
            state  <= ST_DRIVE;
            {a, b} <= target_ab(target_q);
          end
        end
        ST_RESP: begin
          if (resp_rd) begin
            state    <= ST_IDLE;
            resp_vld <= 1'b0;
            resp_ok  <= 1'b0;
            resp_err <= 1'b0;
            req_rd   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FSM_AB_STEER_STATS_EN
  logic inc_ok, inc_err, inc_retry;

  assign inc_ok    = resp_vld && resp_rd && resp_ok;
  assign inc_err   = resp_vld && resp_rd && resp_err;
  // Mirrors the CHECK -> DRIVE branch above.
  assign inc_retry = (state == ST_CHECK) && (st_code != target_code(target_q)) &&
                     code_legal(st_code) && (retries < RW'(MAX_RETRY));

  fsm_ab_steer_stats #(.STAT_W(STAT_W)) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (stat_clr),
    .inc_ok     (inc_ok),
    .inc_err    (inc_err),
    .inc_retry  (inc_retry),
    .stat_ok    (stat_ok),
    .stat_err   (stat_err),
    .stat_retry (stat_retry)
  );
`endif

endmodule

// File: tb/tb_fsm_ab_steer_driver.sv
// Scoreboard bench for fsm_ab_steer_driver with a behavioural remote a/b FSM.
module tb_fsm_ab_steer_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_vld = 1'b0;
  logic       req_rd;
  logic [2:0] st_code;
  logic       a, b;
  logic       resp_ok, resp_err, resp_vld;
  logic       resp_rd = 1'b1;
`ifdef FSM_AB_STEER_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_ok, stat_err, stat_retry;
`endif

  fsm_ab_steer_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_target (req_target),
    .req_vld    (req_vld),
    .req_rd     (req_rd),
    .st_code    (st_code),
    .a          (a),
    .b          (b),
    .resp_ok    (resp_ok),
    .resp_err   (resp_err),
    .resp_vld   (resp_vld),
    .resp_rd    (resp_rd)
`ifdef FSM_AB_STEER_STATS_EN
    , .stat_clr   (stat_clr)
    , .stat_ok    (stat_ok)
    , .stat_err   (stat_err)
    , .stat_retry (stat_retry)
`endif
  );

  always #5 clk = ~clk;

  // Remote FSM: (1,0)->st0, (0,1)->st1, (1,1)->st2, (0,0) holds; ignore_n drops drives.
  logic [2:0] rem_code = 3'b001;
  logic       illegal = 1'b0;
  int         ignore_n = 0;

  always @(posedge clk) begin
    if (a || b) begin
      if (ignore_n > 0) ignore_n = ignore_n - 1;
      else begin
        case ({a, b})
          2'b10:   rem_code <= 3'b001;
          2'b01:   rem_code <= 3'b010;
          default: rem_code <= 3'b011;
        endcase
      end
    end
  end

  assign st_code = illegal ? 3'b111 : rem_code;

  typedef struct {
    logic       ok;
    logic       err;
    int         lat;    // edges from accept to resp_vld rising (spec cycles - 1)
    int         drives;
    logic [1:0] ab;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tracks accepts and drive pulses, pops the scoreboard on each new response.
  int   acc_cyc = 0;
  int   drives = 0;
  int   last_drive = 0;
  logic prev_vld = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (req_vld && req_rd) begin
        acc_cyc = cyc + 1;
        drives  = 0;
      end
      if (a || b) begin
        if (sb.size() == 0) check("drive_unexpected", 1, 0);
        else begin
          check("drive_pattern", int'({a, b}), int'(sb[0].ab));
          if (drives > 0) check("drive_spacing", cyc - last_drive, 2);
          drives++;
          last_drive = cyc;
        end
      end
      if (resp_vld && !prev_vld) begin
        if (sb.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("resp_ok", int'(resp_ok), int'(mon_e.ok));
          check("resp_err", int'(resp_err), int'(mon_e.err));
          check("resp_latency", cyc - acc_cyc, mon_e.lat);
          check("drive_count", drives, mon_e.drives);
          check("remote_code", int'(st_code), int'(mon_e.code));
        end
      end
      prev_vld = resp_vld;
    end
  end

  task automatic push_exp(input logic ok, input int lat, input int drv,
                          input logic [1:0] ab, input logic [2:0] code);
    exp_t e;
    e.ok = ok; e.err = !ok; e.lat = lat; e.drives = drv; e.ab = ab; e.code = code;
    sb.push_back(e);
  endtask

  task automatic accept(input logic [1:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_rd && n < 20) begin @(negedge clk); n++; end
    check("req_rd_ready", int'(req_rd), 1);
    req_target = t;
    req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    req_target = 2'd3;  // must not matter after acceptance
  endtask

  task automatic do_req(input logic [1:0] t, input logic ok, input int lat, input int drv,
                        input logic [1:0] ab, input logic [2:0] code);
    int n;
    push_exp(ok, lat, drv, ab, code);
    accept(t);
    n = 0;
    @(negedge clk);
    while (!(resp_vld && resp_rd) && n < 40) begin @(negedge clk); n++; end
    check("resp_handshake", int'(resp_vld && resp_rd), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n;
    exp_t dropped;

    #12;
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_req_rd", int'(req_rd), 0);
    check("rst_resp_vld", int'(resp_vld), 0);
    check("rst_resp_ok", int'(resp_ok), 0);
    check("rst_resp_err", int'(resp_err), 0);
`ifdef FSM_AB_STEER_STATS_EN
    check("rst_stat_ok", int'(stat_ok), 0);
    check("rst_stat_retry", int'(stat_retry), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // target, ok, latency, drives, pattern, remote code after
    do_req(2'd2, 1'b1, 2, 1, 2'b11, 3'b011);   // st0 -> st2
    do_req(2'd1, 1'b1, 2, 1, 2'b01, 3'b010);   // st2 -> st1
    do_req(2'd1, 1'b1, 0, 0, 2'b00, 3'b010);   // already there
    do_req(2'd3, 1'b0, 0, 0, 2'b00, 3'b010);   // illegal target
    illegal = 1'b1;
    do_req(2'd0, 1'b0, 0, 0, 2'b00, 3'b111);   // illegal remote code
    illegal = 1'b0;
    ignore_n = 3;
    do_req(2'd0, 1'b0, 6, 3, 2'b10, 3'b010);   // retries exhausted
    ignore_n = 1;
    do_req(2'd2, 1'b1, 4, 2, 2'b11, 3'b011);   // success on second attempt
    ignore_n = 0;

    // Back-pressure: response held, stray req_vld ignored.
    resp_rd = 1'b0;
    push_exp(1'b1, 2, 1, 2'b10, 3'b001);
    accept(2'd0);
    n = 0;
    @(negedge clk);
    while (!resp_vld && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      check("hold_resp_vld", int'(resp_vld), 1);
      check("hold_resp_ok", int'(resp_ok), 1);
      check("hold_req_rd", int'(req_rd), 0);
      req_vld = 1'b1;
      req_target = 2'd3;
      @(negedge clk);
    end
    req_vld = 1'b0;
    resp_rd = 1'b1;
    @(negedge clk);
    check("release_resp_vld", int'(resp_vld), 0);
    check("release_req_rd", int'(req_rd), 1);

    // Reset during CHECK drops the request.
    push_exp(1'b1, 2, 1, 2'b11, 3'b011);
    accept(2'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_a", int'(a), 0);
    check("midrst_b", int'(b), 0);
    check("midrst_resp_vld", int'(resp_vld), 0);
    check("midrst_req_rd", int'(req_rd), 0);
    dropped = sb.pop_front();
    repeat (2) @(negedge clk);
`ifdef FSM_AB_STEER_STATS_EN
    check("midrst_stat_ok", int'(stat_ok), 0);
    check("midrst_stat_err", int'(stat_err), 0);
`endif
    rst_n = 1'b1;
    do_req(2'd1, 1'b1, 2, 1, 2'b01, 3'b010);   // st2 -> st1 after reset
    do_req(2'd0, 1'b1, 2, 1, 2'b10, 3'b001);   // st1 -> st0

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
